// File: rtl/risc_32_modify.sv
// risc_32_modify: 5-stage (IF/ID/EX/MEM/WB) 32-bit RISC pipeline with a
// thermally scaled pipeline clock enable. No forwarding, no interlocks;
// register file is write-through so WB results reach ID in the same tick.
// Optional feature macro: TMU_EN (thermal clock scaling via temp_st).
// Without TMU_EN, temp_st is ignored and clk1 is always clk/2.
module risc_32_modify (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] temp_st,
    output logic       clk1
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned AW        = 10;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned NREG      = 32;
    localparam int unsigned RW        = 5;
    localparam int unsigned OPW       = 6;
    localparam int unsigned CNTW      = 3;

    localparam logic [OPW-1:0] OP_ADD  = 6'h00;
    localparam logic [OPW-1:0] OP_SUB  = 6'h01;
    localparam logic [OPW-1:0] OP_MUL  = 6'h02;
    localparam logic [OPW-1:0] OP_DIV  = 6'h03;
    localparam logic [OPW-1:0] OP_AND  = 6'h04;
    localparam logic [OPW-1:0] OP_OR   = 6'h05;
    localparam logic [OPW-1:0] OP_SLT  = 6'h06;
    localparam logic [OPW-1:0] OP_NOP  = 6'h07;
    localparam logic [OPW-1:0] OP_BNEZ = 6'h0D;
    localparam logic [OPW-1:0] OP_BEQZ = 6'h0E;
    localparam logic [OPW-1:0] OP_ADDI = 6'h20;
    localparam logic [OPW-1:0] OP_ADDJ = 6'h21;
    localparam logic [OPW-1:0] OP_SUBI = 6'h22;
    localparam logic [OPW-1:0] OP_MULI = 6'h23;
    localparam logic [OPW-1:0] OP_DIVI = 6'h24;
    localparam logic [OPW-1:0] OP_ANDI = 6'h25;
    localparam logic [OPW-1:0] OP_ORI  = 6'h26;
    localparam logic [OPW-1:0] OP_LW   = 6'h30;
    localparam logic [OPW-1:0] OP_SW   = 6'h31;
    localparam logic [OPW-1:0] OP_HLT  = 6'h3F;

    localparam logic [XLEN-1:0] NOP_INSTR = {OP_NOP, 26'd0};

    // Storage (not reset; contents are loaded externally)
    logic [XLEN-1:0] regb    [NREG];
    logic [XLEN-1:0] mem     [MEM_DEPTH];
    logic [XLEN-1:0] datamem [MEM_DEPTH];

    // Architectural / pipeline state
    logic [XLEN-1:0] pc;
    logic            halted;
    logic            taken_branch;

    logic [XLEN-1:0] if_id_ir;
    logic [XLEN-1:0] if_id_npc;

    logic [OPW-1:0]  id_ex_opcd;
    logic [RW-1:0]   id_ex_rd;
    logic [XLEN-1:0] id_ex_a;
    logic [XLEN-1:0] id_ex_b;
    logic [XLEN-1:0] id_ex_imm;
    logic [XLEN-1:0] id_ex_npc;

    logic [OPW-1:0]  ex_mem_opcd;
    logic [RW-1:0]   ex_mem_rd;
    logic [XLEN-1:0] ex_mem_aluout;
    logic [XLEN-1:0] ex_mem_b;

    logic [OPW-1:0]  mem_wb_opcd;
    logic [RW-1:0]   mem_wb_rd;
    logic [XLEN-1:0] mem_wb_aluout;
    logic [XLEN-1:0] mem_wb_lmd;

    // Thermal divider state
    logic [CNTW-1:0] div_cnt;
    logic [1:0]      cur_temp;

    // Combinational helpers
    logic [1:0]      temp_req_c;
    logic [CNTW-1:0] div_last_c;
    logic [CNTW-1:0] div_half_c;
    logic            tick_c;
    logic            advance_c;

    logic [XLEN-1:0] if_ir_c;
    logic [OPW-1:0]  id_op_c;
    logic [RW-1:0]   id_rd_c;
    logic [RW-1:0]   id_rs_c;
    logic [RW-1:0]   id_bsel_c;
    logic [XLEN-1:0] id_a_c;
    logic [XLEN-1:0] id_b_c;
    logic [XLEN-1:0] id_imm_c;

    logic [XLEN-1:0] ex_opb_c;
    logic [XLEN-1:0] alu_c;
    logic            br_taken_c;
    logic [XLEN-1:0] br_target_c;

    logic [XLEN-1:0] wb_val_c;
    logic            wb_we_c;
    logic            sw_we_c;

    function automatic logic writes_rd(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_SLT,
            OP_ADDI, OP_ADDJ, OP_SUBI, OP_MULI, OP_DIVI, OP_ANDI, OP_ORI,
            OP_LW:   writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [OPW-1:0] op);
        case (op)
            OP_ADDI, OP_ADDJ, OP_SUBI, OP_MULI, OP_DIVI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW: uses_imm = 1'b1;
            default:      uses_imm = 1'b0;
        endcase
    endfunction

    // Requested thermal level; codes above 3 saturate to 3
    always_comb begin
        temp_req_c = 2'd0;
`ifdef TMU_EN
        temp_req_c = temp_st[2] ? 2'd3 : temp_st[1:0];
`endif
    end

    // Divider period terminal count and high-phase length for the applied level
    always_comb begin
        div_last_c = '0;
        div_half_c = '0;
        case (cur_temp)
            2'd0:    begin div_last_c = 3'd1; div_half_c = 3'd1; end
            2'd1:    begin div_last_c = 3'd3; div_half_c = 3'd2; end
            2'd2:    begin div_last_c = 3'd7; div_half_c = 3'd4; end
            default: begin div_last_c = 3'd0; div_half_c = 3'd0; end
        endcase
        tick_c    = (cur_temp != 2'd3) && (div_cnt == '0);
        advance_c = tick_c && !halted && !rst;
    end

    // Divider: new level is applied only at the end of a full clk1 period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            cur_temp <= 2'd0;
            clk1     <= 1'b0;
        end else if (cur_temp == 2'd3) begin
            div_cnt  <= '0;
            clk1     <= 1'b0;
            cur_temp <= temp_req_c;
        end else begin
            clk1 <= (div_cnt < div_half_c);
            if (div_cnt == div_last_c) begin
                div_cnt  <= '0;
                cur_temp <= temp_req_c;
            end else begin
                div_cnt <= div_cnt + CNTW'(1);
            end
        end
    end

    // IF fetch and ID decode with write-through register read
    always_comb begin
        if_ir_c   = mem[pc[AW-1:0]];
        id_op_c   = if_id_ir[31:26];
        id_rd_c   = if_id_ir[25:21];
        id_rs_c   = if_id_ir[20:16];
        id_bsel_c = (id_op_c == OP_SW) ? id_rd_c : if_id_ir[15:11];
        id_imm_c  = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

        id_a_c = regb[id_rs_c];
        if (wb_we_c && (mem_wb_rd == id_rs_c)) id_a_c = wb_val_c;
        if (id_rs_c == '0) id_a_c = '0;

        id_b_c = regb[id_bsel_c];
        if (wb_we_c && (mem_wb_rd == id_bsel_c)) id_b_c = wb_val_c;
        if (id_bsel_c == '0) id_b_c = '0;
    end

    // EX: ALU and branch resolution
    always_comb begin
        ex_opb_c = uses_imm(id_ex_opcd) ? id_ex_imm : id_ex_b;
        alu_c    = '0;
        case (id_ex_opcd)
            OP_ADD, OP_ADDI, OP_ADDJ, OP_LW, OP_SW: alu_c = id_ex_a + ex_opb_c;
            OP_SUB, OP_SUBI:                        alu_c = id_ex_a - ex_opb_c;
            OP_MUL, OP_MULI:                        alu_c = id_ex_a * ex_opb_c;
            OP_DIV, OP_DIVI:
                alu_c = (ex_opb_c == '0) ? '0 : id_ex_a / ex_opb_c;
            OP_AND, OP_ANDI:                        alu_c = id_ex_a & ex_opb_c;
            OP_OR, OP_ORI:                          alu_c = id_ex_a | ex_opb_c;
            OP_SLT:
                alu_c = {31'd0, ($signed(id_ex_a) < $signed(ex_opb_c))};
            default:                                alu_c = '0;
        endcase
        br_taken_c  = ((id_ex_opcd == OP_BNEZ) && (id_ex_a != '0)) ||
                      ((id_ex_opcd == OP_BEQZ) && (id_ex_a == '0));
        br_target_c = id_ex_npc + id_ex_imm;
    end

    // WB result select and architectural write enables
    always_comb begin
        wb_val_c = (mem_wb_opcd == OP_LW) ? mem_wb_lmd : mem_wb_aluout;
        wb_we_c  = advance_c && writes_rd(mem_wb_opcd) && (mem_wb_rd != '0);
        sw_we_c  = advance_c && (ex_mem_opcd == OP_SW);
    end

    // Pipeline registers; a taken branch squashes ID now and IF next tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= '0;
            halted        <= 1'b0;
            taken_branch  <= 1'b0;
            if_id_ir      <= NOP_INSTR;
            if_id_npc     <= '0;
            id_ex_opcd    <= OP_NOP;
            id_ex_rd      <= '0;
            id_ex_a       <= '0;
            id_ex_b       <= '0;
            id_ex_imm     <= '0;
            id_ex_npc     <= '0;
            ex_mem_opcd   <= OP_NOP;
            ex_mem_rd     <= '0;
            ex_mem_aluout <= '0;
            ex_mem_b      <= '0;
            mem_wb_opcd   <= OP_NOP;
            mem_wb_rd     <= '0;
            mem_wb_aluout <= '0;
            mem_wb_lmd    <= '0;
        end else if (advance_c) begin
            pc           <= br_taken_c ? br_target_c : pc + XLEN'(1);
            taken_branch <= br_taken_c;

            if_id_ir  <= if_ir_c;
            if_id_npc <= pc + XLEN'(1);

            id_ex_opcd <= (br_taken_c || taken_branch) ? OP_NOP : id_op_c;
            id_ex_rd   <= id_rd_c;
            id_ex_a    <= id_a_c;
            id_ex_b    <= id_b_c;
            id_ex_imm  <= id_imm_c;
            id_ex_npc  <= if_id_npc;

            ex_mem_opcd   <= id_ex_opcd;
            ex_mem_rd     <= id_ex_rd;
            ex_mem_aluout <= alu_c;
            ex_mem_b      <= id_ex_b;

            mem_wb_opcd   <= ex_mem_opcd;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_aluout <= ex_mem_aluout;
            mem_wb_lmd    <= datamem[ex_mem_aluout[AW-1:0]];

            if (mem_wb_opcd == OP_HLT) halted <= 1'b1;
        end
    end

    // Register file and data memory writes (storage is never reset)
    always_ff @(posedge clk) begin
        if (wb_we_c) regb[mem_wb_rd] <= wb_val_c;
        if (sw_we_c) datamem[ex_mem_aluout[AW-1:0]] <= ex_mem_b;
    end

endmodule

// File: tb/tb_risc_32_modify.sv
// Directed bench for risc_32_modify: table of single-instruction ALU vectors
// plus hand-written programs for hazards, branches, memory, halt, reset and
// clock scaling (thermal checks only when TMU_EN is defined).
module tb_risc_32_modify;

    localparam logic [5:0] NOP = 6'h07;
    localparam logic [5:0] HLT = 6'h3F;
    localparam logic [5:0] ADD = 6'h00;
    localparam logic [5:0] SUB = 6'h01;
    localparam logic [5:0] DIV = 6'h03;
    localparam logic [5:0] ADDI = 6'h20;
    localparam logic [5:0] MULI = 6'h23;
    localparam logic [5:0] ANDI = 6'h25;
    localparam logic [5:0] LW = 6'h30;
    localparam logic [5:0] SW = 6'h31;
    localparam logic [5:0] BNEZ = 6'h0D;
    localparam logic [5:0] BEQZ = 6'h0E;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] temp_st = 3'd0;
    logic       clk1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    risc_32_modify dut (
        .clk(clk),
        .rst(rst),
        .temp_st(temp_st),
        .clk1(clk1)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        use_imm;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [4:0] rd,
                           input logic use_imm, input logic [15:0] imm, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pre, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.rd = rd; v.use_imm = use_imm; v.imm = imm;
        v.a = a; v.b = b; v.pre = pre; v.exp = exp;
        vq.push_back(v);
    endtask

    // Hold reset, clear registers and fill instruction memory with NOPs
    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.mem[i] = {NOP, 26'd0};
        for (int i = 0; i < 32; i++) dut.regb[i] = 32'd0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (dut.halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halted"}, 32'(dut.halted), 32'd1);
    endtask

    // Count clk1 rising edges and pc advance over a window of clk cycles
    task automatic measure(input int cycles, output int rises, output logic [31:0] pc_delta);
        logic prev;
        logic [31:0] pc0;
        rises = 0;
        @(negedge clk);
        prev = clk1;
        pc0  = dut.pc;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (clk1 && !prev) rises++;
            prev = clk1;
        end
        pc_delta = dut.pc - pc0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_hold;
        int          rises;
        logic [31:0] pcd;

        // Vector table: r1 = a, r2 = b, result in rd
        add_vec("add",    ADD,   5'd3, 1'b0, 16'h0000, 32'd5,        32'd7,        32'd0,  32'd12);
        add_vec("sub",    SUB,   5'd3, 1'b0, 16'h0000, 32'd5,        32'd7,        32'd0,  32'hFFFF_FFFE);
        add_vec("mul",    6'h02, 5'd3, 1'b0, 16'h0000, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'h0001_0000);
        add_vec("div",    DIV,   5'd3, 1'b0, 16'h0000, 32'd100,      32'd7,        32'd0,  32'd14);
        add_vec("div0",   DIV,   5'd3, 1'b0, 16'h0000, 32'd100,      32'd0,        32'd9,  32'd0);
        add_vec("divu",   DIV,   5'd3, 1'b0, 16'h0000, 32'hFFFF_FFFF, 32'd2,       32'd0,  32'h7FFF_FFFF);
        add_vec("and",    6'h04, 5'd3, 1'b0, 16'h0000, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0000_F000);
        add_vec("or",     6'h05, 5'd3, 1'b0, 16'h0000, 32'h0000_F0F0, 32'h0000_0F00, 32'd0, 32'h0000_FFF0);
        add_vec("slt_t",  6'h06, 5'd3, 1'b0, 16'h0000, 32'hFFFF_FFFF, 32'd1,       32'd7,  32'd1);
        add_vec("slt_f",  6'h06, 5'd3, 1'b0, 16'h0000, 32'd5,        32'd3,        32'd7,  32'd0);
        add_vec("nop",    NOP,   5'd3, 1'b0, 16'h0000, 32'd5,        32'd7,        32'hDEAD, 32'hDEAD);
        add_vec("undef",  6'h15, 5'd3, 1'b0, 16'h0000, 32'd5,        32'd7,        32'hBEEF, 32'hBEEF);
        add_vec("addi",   ADDI,  5'd3, 1'b1, 16'hFFFD, 32'd5,        32'd0,        32'd0,  32'd2);
        add_vec("addi2",  6'h21, 5'd3, 1'b1, 16'h0064, 32'd5,        32'd0,        32'd0,  32'd105);
        add_vec("subi",   6'h22, 5'd3, 1'b1, 16'h0001, 32'd5,        32'd0,        32'd0,  32'd4);
        add_vec("muli",   MULI,  5'd3, 1'b1, 16'hFFFE, 32'd6,        32'd0,        32'd0,  32'hFFFF_FFF4);
        add_vec("divi",   6'h24, 5'd3, 1'b1, 16'hFFFF, 32'd100,      32'd0,        32'd3,  32'd0);
        add_vec("andi",   ANDI,  5'd3, 1'b1, 16'h8000, 32'hFFFF_FFFF, 32'd0,       32'd0,  32'hFFFF_8000);
        add_vec("ori",    6'h26, 5'd3, 1'b1, 16'h0010, 32'd1,        32'd0,        32'd0,  32'h0000_0011);
        add_vec("r0",     ADDI,  5'd0, 1'b1, 16'h0005, 32'd5,        32'd0,        32'd0,  32'd0);

        // Reset state
        @(negedge clk);
        check("rst_pc",     dut.pc, 32'd0);
        check("rst_halted", 32'(dut.halted), 32'd0);
        check("rst_clk1",   32'(clk1), 32'd0);
        check("rst_opcd",   32'(dut.id_ex_opcd), 32'h07);
        check("rst_a",      dut.id_ex_a, 32'd0);
        check("rst_alu",    dut.ex_mem_aluout, 32'd0);

        // Table-driven single-instruction vectors
        foreach (vq[k]) begin
            hold_reset();
            dut.regb[1] = vq[k].a;
            dut.regb[2] = vq[k].b;
            dut.regb[vq[k].rd] = vq[k].pre;
            dut.mem[0] = vq[k].use_imm ? enc_i(vq[k].op, vq[k].rd, 5'd1, vq[k].imm)
                                       : enc_r(vq[k].op, vq[k].rd, 5'd1, 5'd2);
            dut.mem[1] = {HLT, 26'd0};
            release_reset();
            run_to_halt(vq[k].name, 100);
            check(vq[k].name, dut.regb[vq[k].rd], vq[k].exp);
        end

        // NOP-padded dependency program, then halt freezes pc at 17
        hold_reset();
        dut.mem[0]  = enc_i(ADDI, 5'd1, 5'd0, 16'd10);
        dut.mem[1]  = enc_i(ADDI, 5'd2, 5'd0, 16'd30);
        dut.mem[4]  = enc_r(ADD,  5'd4, 5'd1, 5'd2);
        dut.mem[5]  = enc_i(ADDI, 5'd3, 5'd0, 16'd20);
        dut.mem[8]  = enc_r(SUB,  5'd5, 5'd3, 5'd1);
        dut.mem[11] = enc_r(ADD,  5'd7, 5'd3, 5'd5);
        dut.mem[12] = {HLT, 26'd0};
        release_reset();
        run_to_halt("prog", 200);
        check("prog_r1", dut.regb[1], 32'd10);
        check("prog_r2", dut.regb[2], 32'd30);
        check("prog_r4", dut.regb[4], 32'd40);
        check("prog_r3", dut.regb[3], 32'd20);
        check("prog_r5", dut.regb[5], 32'd10);
        check("prog_r7", dut.regb[7], 32'd30);
        repeat (10) @(negedge clk);
        check("halt_pc", dut.pc, 32'd17);

        // Store / load
        hold_reset();
        dut.regb[3] = 32'd20;
        dut.regb[7] = 32'd30;
        dut.datamem[0] = 32'hFFFF_FFFF;
        dut.datamem[1] = 32'hFFFF_FFFF;
        dut.mem[0] = enc_i(SW, 5'd3, 5'd0, 16'd0);
        dut.mem[1] = enc_i(LW, 5'd6, 5'd0, 16'd0);
        dut.mem[2] = enc_i(SW, 5'd7, 5'd0, 16'd1);
        dut.mem[3] = {HLT, 26'd0};
        release_reset();
        run_to_halt("mem", 200);
        check("mem_d0", dut.datamem[0], 32'd20);
        check("mem_r6", dut.regb[6], 32'd20);
        check("mem_d1", dut.datamem[1], 32'd30);

        // Mixed arithmetic with preset operands
        hold_reset();
        dut.regb[1] = 32'd10; dut.regb[2] = 32'd30; dut.regb[3] = 32'd20;
        dut.regb[5] = 32'd10; dut.regb[12] = 32'd5;
        dut.mem[0] = enc_i(MULI, 5'd9, 5'd2, 16'd2);
        dut.mem[1] = enc_r(DIV,  5'd10, 5'd3, 5'd1);
        dut.mem[2] = enc_i(ANDI, 5'd11, 5'd5, 16'd8);
        dut.mem[3] = enc_r(DIV,  5'd12, 5'd3, 5'd0);
        dut.mem[4] = {HLT, 26'd0};
        release_reset();
        run_to_halt("arith", 200);
        check("arith_r9",  dut.regb[9],  32'd60);
        check("arith_r10", dut.regb[10], 32'd2);
        check("arith_r11", dut.regb[11], 32'd8);
        check("arith_r12", dut.regb[12], 32'd0);

        // Branches: not-taken BNEZ, taken BEQZ squashes two and skips one
        hold_reset();
        dut.mem[0] = enc_i(BNEZ, 5'd0, 5'd0, 16'd10);
        dut.mem[1] = enc_i(ADDI, 5'd24, 5'd0, 16'd9);
        dut.mem[2] = enc_i(BEQZ, 5'd0, 5'd0, 16'd3);
        dut.mem[3] = enc_i(ADDI, 5'd20, 5'd0, 16'd1);
        dut.mem[4] = enc_i(ADDI, 5'd21, 5'd0, 16'd1);
        dut.mem[5] = enc_i(ADDI, 5'd22, 5'd0, 16'd1);
        dut.mem[6] = enc_i(ADDI, 5'd23, 5'd0, 16'd7);
        dut.mem[7] = {HLT, 26'd0};
        release_reset();
        run_to_halt("br", 200);
        check("br_r24", dut.regb[24], 32'd9);
        check("br_r20", dut.regb[20], 32'd0);
        check("br_r21", dut.regb[21], 32'd0);
        check("br_r22", dut.regb[22], 32'd0);
        check("br_r23", dut.regb[23], 32'd7);

        // Asynchronous reset mid-program, then rerun from mem[0]
        hold_reset();
        dut.mem[0] = enc_i(ADDI, 5'd0, 5'd0, 16'd5);
        dut.mem[1] = enc_i(ADDI, 5'd25, 5'd0, 16'd3);
        dut.mem[5] = {HLT, 26'd0};
        release_reset();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pc",   dut.pc, 32'd0);
        check("mid_rst_clk1", 32'(clk1), 32'd0);
        dut.regb[25] = 32'hAA;
        release_reset();
        run_to_halt("rerun", 200);
        check("rerun_r25", dut.regb[25], 32'd3);
        check("rerun_r0",  dut.regb[0], 32'd0);

`ifdef TMU_EN
        // Thermal scaling: settle 16 clk after each change, then measure 48 clk
        hold_reset();
        release_reset();
        begin
            logic [2:0] temps [5];
            int         exp_r [5];
            temps[0] = 3'd0; temps[1] = 3'd1; temps[2] = 3'd2; temps[3] = 3'd3; temps[4] = 3'd0;
            exp_r[0] = 24;   exp_r[1] = 12;   exp_r[2] = 6;    exp_r[3] = 0;    exp_r[4] = 24;
            for (int t = 0; t < 5; t++) begin
                temp_st = temps[t];
                repeat (16) @(negedge clk);
                measure(48, rises, pcd);
                check($sformatf("tmu_rises_%0d", t), 32'(rises), 32'(exp_r[t]));
                check($sformatf("tmu_pc_%0d", t),    pcd,        32'(exp_r[t]));
            end
            temp_st = 3'd5;
            repeat (16) @(negedge clk);
            measure(48, rises, pcd);
            check("tmu_code5_rises", 32'(rises), 32'd0);
        end
        // Execution at the slowest running level
        hold_reset();
        temp_st = 3'd2;
        dut.regb[1] = 32'd6;
        dut.mem[0] = enc_i(MULI, 5'd3, 5'd1, 16'd7);
        dut.mem[1] = {HLT, 26'd0};
        release_reset();
        run_to_halt("tmu_slow", 400);
        check("tmu_slow_r3", dut.regb[3], 32'd42);
        temp_st = 3'd0;
`else
        // Without thermal scaling, temp_st is ignored: clk1 stays clk/2
        hold_reset();
        temp_st = 3'd3;
        release_reset();
        repeat (8) @(negedge clk);
        measure(48, rises, pcd);
        check("fixed_rises", 32'(rises), 32'd24);
        check("fixed_pc",    pcd,        32'd24);
        temp_st = 3'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_32_modify.md
RISC_32_MODIFY -- requirements
Module: risc_32_modify

Interface
REQ-001 The module SHALL have ports clk, rst, temp_st, clk1. The clock and reset are settled; the widths and meanings below are binding.
REQ-002 The interface SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  async active-high reset.
REQ-005 temp_st  input  3  thermal state: 0 equal, 1 small rise, 2 large rise, 3 extreme; codes 4-7 are treated as 3.
REQ-006 clk1  output  1  scaled pipeline clock, registered on clk.
REQ-007 The following internal names SHALL be hierarchically accessible to benches:
- regb: 32x32 register file.
- mem: 1024x32 instruction memory.
- datamem: 1024x32 data memory.
- pc, halted.
- id_ex_opcd, id_ex_a, id_ex_b, id_ex_imm, ex_mem_aluout.

Function
REQ-008 Pipeline SHALL have 5 stages: IF, ID, EX, MEM, WB. All stages advance together only on a clk edge where tick=1 (see REQ-020).
REQ-009 Instruction fields:
- [31:26] opcode.
- [25:21] rd; also the store-data register for SW.
- [20:16] rs.
- [15:11] rt.
- [15:0] imm, sign-extended to 32 bits.
REQ-010 R-type opcodes compute rd = rs op rt:
- 0x00 ADD, 0x01 SUB, 0x02 MUL (low 32 bits), 0x03 DIV (unsigned; divide by zero gives 0).
- 0x04 AND, 0x05 OR, 0x06 SLT (signed, result 0/1).
- 0x07 NOP (no write).
REQ-011 Immediate opcodes compute rd = rs op imm:
- 0x20 ADDI, 0x21 ADDI (alias), 0x22 SUBI, 0x23 MULI, 0x24 DIVI, 0x25 ANDI, 0x26 ORI.
REQ-012 Memory opcodes: 0x30 LW: rd = datamem[(rs+imm)[9:0]]. 0x31 SW: datamem[(rs+imm)[9:0]] = rd. The SW write occurs in MEM.
REQ-013 Branch opcodes: 0x0D BNEZ and 0x0E BEQZ test rs; target = npc + imm.
- Branch resolves in EX.
- If taken, the two younger instructions SHALL be squashed (no register or memory writes), and pc = target.
REQ-014 0x3F HLT: when HLT reaches WB, halted SHALL be set to 1. From the next tick, pc SHALL freeze and no register or memory write SHALL occur. Undefined opcodes SHALL act as NOP.
REQ-015 r0 SHALL read as 0; writes to r0 SHALL be ignored.
REQ-016 Register file SHALL be write-through: a WB write in a tick is visible to the ID read in the same tick. Results are therefore usable by the 3rd following instruction.
REQ-017 There SHALL be no forwarding and no interlocks; software pads dependencies with NOPs.
REQ-018 pc SHALL be a 32-bit word index into mem and SHALL increment by 1 per tick.
REQ-019 Thermal divider: clk1 period in clk cycles SHALL be 2 for temp 0, 4 for temp 1, 8 for temp 2. For temp 3, clk1 SHALL hold 0 and the pipeline SHALL freeze with all state retained.
REQ-020 tick SHALL be 1 on the clk edge where clk1 rises.
REQ-021 A temp_st change SHALL take effect at the next completed clk1 period. Leaving temp 3 SHALL restart the divider from count 0.

Reset
REQ-022 rst=1 SHALL force the following, asynchronously:
- pc=0, halted=0, clk1=0, divider count=0.
- All pipeline registers 0, with opcode fields loaded as NOP (0x07).
- taken-branch flag 0.
REQ-023 regb, mem and datamem SHALL NOT be reset (preloaded by bench). Reset mid-execution SHALL restart fetch at mem[0].

Configuration
REQ-024 Macro TMU_EN defined: thermal scaling per REQ-019..021.
REQ-025 Macro TMU_EN undefined: temp_st SHALL be ignored and clk1 SHALL always be clk/2.

Verification
REQ-026 Program with NOP-padded dependencies [ADDI r1,r0,10; ADDI r2,r0,30; NOP; NOP; ADD r4,r1,r2; ADDI r3,r0,20; NOP; NOP; SUB r5,r3,r1; NOP; NOP; ADD r7,r3,r5; HLT] -> r1=10, r2=30, r4=40, r3=20, r5=10, r7=30, halted=1.
REQ-027 With r3=20: SW r3,0(r0); LW r6,0(r0) -> datamem[0]=20, r6=20. Further SW r7,1(r0) with r7=30 -> datamem[1]=30.
REQ-028 With r2=30, r3=20, r1=10, r5=10:
- MULI r9,r2,2 -> r9=60.
- DIV r10,r3,r1 -> r10=2.
- ANDI r11,r5,8 -> r11=8.
- DIV by r0 -> 0.
REQ-029 temp_st sequence 0, 1, 2, 3, 0 held for 64 clk each -> clk1 period 2, 4, 8, then flat 0 with pc constant, then period 2 with execution resuming and correct results.
REQ-030 Assert rst mid-program -> pc=0 and clk1=0 immediately. After release, the program reruns from mem[0]; ADDI r0,r0,5 leaves r0=0.
